// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the bit-serial subtractor
// Purpose: FSM state encoding, default operand width and a counter-width helper.
// Ports: none (package).
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bits needed to count 0..v-1; never less than one so the counter always exists.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_bit_cell.sv
// rtl/serial_subtractor_sub_bit_cell.sv - one-bit full adder cell
// Purpose: combinational full adder used one bit per clock by the serial datapath.
// Ports: a, b, cin (inputs, 1 bit); s (sum), cout (carry out).
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first
// Purpose: computes n1 - n2 one bit per clock as n1 + ~n2 + 1 through a single full adder.
// Ports: clk, reset (sync, active-high); start, n1, n2 (request and operands);
//        busy, done (handshake); result, bo (borrow), overflow (signed overflow).
import serial_subtractor_pkg::*;

module serial_subtractor #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bo,
  output logic             overflow
);

  localparam int CW = clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             b_inv;
  logic             s;
  logic             cout;
  logic             last;

  // Subtraction as addition of the inverted subtrahend; carry starts at 1.
  assign b_inv = ~b_sh[0];
  assign last  = (count == CW'(WIDTH - 1));
  assign busy  = (state == ST_RUN);

  sub_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_inv),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      count    <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      bo       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= n1;
            b_sh  <= n2;
            a_msb <= n1[WIDTH-1];
            b_msb <= n2[WIDTH-1];
            carry <= 1'b1;
            count <= '0;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= {s, acc[WIDTH-1:1]};
          carry <= cout;
          count <= count + 1'b1;
          if (last) begin
            // The bit just computed is the result MSB, so flags use s directly.
            count    <= '0;
            result   <= {s, acc[WIDTH-1:1]};
            bo       <= ~cout;
            overflow <= (a_msb != b_msb) && (s != a_msb);
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         bo;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] n1;
    logic [W-1:0] n2;
    logic [W-1:0] res;
    logic         bo;
    logic         ov;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] n1;
  logic [W-1:0] n2;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         bo;
  logic         overflow;

  int   checks;
  int   failures;
  exp_t sb[$];
  vec_t vecs[5];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .n1       (n1),
    .n2       (n2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .bo       (bo),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua, ub, sa, sbv, d;
    ua  = int'(a);
    ub  = int'(b);
    sa  = a[W-1] ? ua - (1 << W) : ua;
    sbv = b[W-1] ? ub - (1 << W) : ub;
    d   = sa - sbv;
    e.res = W'(ua - ub);
    e.bo  = (ua < ub);
    e.ov  = (d > (1 << (W - 1)) - 1) || (d < -(1 << (W - 1)));
    return e;
  endfunction

  // Scoreboard consumer: every done pulse pops one expected record.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("bo", 32'(bo), 32'(e.bo));
        check("overflow", 32'(overflow), 32'(e.ov));
      end
    end
  end

  // Called at a negedge; returns just after the accepting edge with new operands scrambled.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    start = 1'b1;
    n1 = a;
    n2 = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    n1 = W'($urandom);
    n2 = W'($urandom);
  endtask

  task automatic wait_done(input int hazard, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 4 * W + 4; i++) begin
      @(negedge clk);
      if (hazard != 0 && i == 1) begin
        start = 1'b1;
        n1 = '1;
      end
      if (hazard != 0 && i == 2) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  initial begin
    int   lat, bcnt, seen;
    exp_t e;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    n1 = '0;
    n2 = '0;

    vecs[0] = '{n1: 4'b0101, n2: 4'b0011, res: 4'b0010, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{n1: 4'b0011, n2: 4'b0101, res: 4'b1110, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{n1: 4'b1000, n2: 4'b0001, res: 4'b0111, bo: 1'b0, ov: 1'b1};
    vecs[3] = '{n1: 4'b0111, n2: 4'b1111, res: 4'b1000, bo: 1'b1, ov: 1'b1};
    vecs[4] = '{n1: 4'b0000, n2: 4'b0000, res: 4'b0000, bo: 1'b0, ov: 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_bo", 32'(bo), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      e = '{res: vecs[v].res, bo: vecs[v].bo, ov: vecs[v].ov};
      launch(vecs[v].n1, vecs[v].n2, e);
      wait_done(0, lat, bcnt);
      check("latency", 32'(lat), 32'(W));
      check("busy_cycles", 32'(bcnt), 32'(W));
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'(0));
      check("hold_result", 32'(result), 32'(vecs[v].res));
    end

    // start re-asserted with n1=1111 during RUN must be ignored.
    e = '{res: 4'b0010, bo: 1'b0, ov: 1'b0};
    launch(4'b0101, 4'b0011, e);
    wait_done(1, lat, bcnt);
    check("restart_ignored_latency", 32'(lat), 32'(W));
    @(negedge clk);
    check("restart_no_extra_busy", 32'(busy), 32'(0));

    // Back-to-back: second start presented in the done cycle of the first.
    @(negedge clk);
    e = '{res: 4'b0010, bo: 1'b0, ov: 1'b0};
    launch(4'b0101, 4'b0011, e);
    wait_done(0, lat, bcnt);
    check("b2b_first_latency", 32'(lat), 32'(W));
    e = '{res: 4'b0000, bo: 1'b0, ov: 1'b0};
    launch(4'b0000, 4'b0000, e);
    wait_done(0, lat, bcnt);
    check("b2b_second_latency", 32'(lat), 32'(W));
    check("b2b_second_busy", 32'(bcnt), 32'(W));

    // Reset in RUN cycle 2 aborts with cleared outputs and no done.
    @(negedge clk);
    e = '{res: 4'b1110, bo: 1'b1, ov: 1'b0};
    launch(4'b0011, 4'b0101, e);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_result", 32'(result), 32'(0));
    check("abort_bo", 32'(bo), 32'(0));
    check("abort_overflow", 32'(overflow), 32'(0));
    reset = 1'b0;
    sb.delete();
    seen = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'(0));

    // Exhaustive sweep against the reference model.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        launch(W'(a), W'(b), model(W'(a), W'(b)));
        wait_done(0, lat, bcnt);
        if (lat != W) check("sweep_latency", 32'(lat), 32'(W));
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
